// File: rtl/program_loader_if.sv
// Instruction-memory load/write port between the program loader and the memory manager.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) ();
  logic                  load_we;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;

  modport master (output load_we, load_addr, load_data);
  modport slave  (input  load_we, load_addr, load_data);
endinterface

// File: rtl/program_loader.sv
// Front-panel program loader: debounced keys pack SW bytes into instructions written to sequential addresses.
// Optional running checksum of committed instructions when LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int WORD_WIDTH      = 8,
  parameter int INSTR_BYTES     = 2,
  parameter int ADDR_WIDTH      = 8,
  parameter int DEPTH           = 256,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [9:0]                      SW,
  input  logic [3:0]                      KEY,
  program_loader_if.master                mem,
  output logic                            core_hold,
  output logic [ADDR_WIDTH:0]             instr_count,
  output logic [$clog2(INSTR_BYTES):0]    byte_idx,
  output logic                            full,
  output logic [9:0]                      LEDR,
  output logic [WORD_WIDTH-1:0]           checksum
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BI_W  = $clog2(INSTR_BYTES) + 1;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BI_W-1:0]       BI_LAST   = BI_W'(INSTR_BYTES - 1);
  localparam logic [CW-1:0]         DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]         DEPTH_M1  = CW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {EDIT, COMMIT, RUN} state_t;

  logic [2:0]             sync1, sync2, accepted, key_ev;
  logic [2:0][CNT_W-1:0]  db_cnt;
  logic                   enter_ev, run_ev, clear_ev;
  logic [WORD_WIDTH-1:0]  entry;
  logic [INSTR_BYTES-1:0][WORD_WIDTH-1:0] asm_q, asm_nxt;
  state_t                 state;
  logic                   unused_ok;

  assign unused_ok = ^{SW[9:8], KEY[3]};
  assign entry     = WORD_WIDTH'(SW[7:0]);

  // Keys are active-low; synced level is inverted so 1 means pressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '1;
      sync2    <= '1;
      accepted <= '0;
      key_ev   <= '0;
      db_cnt   <= '0;
    end else begin
      sync1 <= KEY[2:0];
      sync2 <= sync1;
      for (int k = 0; k < 3; k++) begin
        key_ev[k] <= 1'b0;
        if (~sync2[k] != accepted[k]) begin
          if (db_cnt[k] == CNT_LAST) begin
            accepted[k] <= ~sync2[k];
            key_ev[k]   <= ~sync2[k];
            db_cnt[k]   <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + 1'b1;
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  assign enter_ev = key_ev[0];
  assign run_ev   = key_ev[1];
  assign clear_ev = key_ev[2];

  always_comb begin
    asm_nxt = asm_q;
    for (int i = INSTR_BYTES - 1; i > 0; i--) asm_nxt[i] = asm_q[i-1];
    asm_nxt[0] = entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= EDIT;
      asm_q         <= '0;
      mem.load_we   <= 1'b0;
      mem.load_addr <= '0;
      mem.load_data <= '0;
      instr_count   <= '0;
      byte_idx      <= '0;
      full          <= 1'b0;
      core_hold     <= 1'b1;
    end else begin
      case (state)
        EDIT: begin
          if (clear_ev) begin
            mem.load_addr <= '0;
            instr_count   <= '0;
            byte_idx      <= '0;
            full          <= 1'b0;
          end else if (run_ev) begin
            state     <= RUN;
            core_hold <= 1'b0;
            byte_idx  <= '0;
          end else if (enter_ev && !full) begin
            asm_q    <= asm_nxt;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == BI_LAST) begin
              state         <= COMMIT;
              mem.load_we   <= 1'b1;
              mem.load_data <= asm_nxt;
            end
          end
        end
        COMMIT: begin
          mem.load_we   <= 1'b0;
          mem.load_addr <= (mem.load_addr == ADDR_LAST) ? '0 : mem.load_addr + 1'b1;
          if (instr_count != DEPTH_C) instr_count <= instr_count + 1'b1;
          if (instr_count == DEPTH_M1) full <= 1'b1;
          byte_idx <= '0;
          state    <= EDIT;
        end
        RUN: begin
          if (run_ev) begin
            state     <= EDIT;
            core_hold <= 1'b1;
          end
        end
        default: state <= EDIT;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] cks_q, instr_xor;

  always_comb begin
    instr_xor = '0;
    for (int i = 0; i < INSTR_BYTES; i++) instr_xor = instr_xor ^ asm_q[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cks_q <= '0;
    end else if (state == EDIT && clear_ev) begin
      cks_q <= '0;
    end else if (state == COMMIT) begin
      cks_q <= cks_q ^ instr_xor;
    end
  end

  assign checksum  = cks_q;
  assign LEDR[9:3] = core_hold ? cks_q[6:0] : 7'd0;
`else
  assign checksum  = '0;
  assign LEDR[9:3] = 7'd0;
`endif

  assign LEDR[0] = ~core_hold;
  assign LEDR[1] = full;
  assign LEDR[2] = (byte_idx != '0);

endmodule

// File: tb/tb_program_loader.sv
// Randomised key-press bench for program_loader with a queue-based write scoreboard.
module tb_program_loader;
  localparam int DEPTH = 4;
  localparam int DB    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  SW;
  logic [3:0]  KEY;
  logic        core_hold;
  logic [8:0]  instr_count;
  logic [1:0]  byte_idx;
  logic        full;
  logic [9:0]  LEDR;
  logic [7:0]  checksum;

  program_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) mem ();

  program_loader #(
    .WORD_WIDTH(8), .INSTR_BYTES(2), .ADDR_WIDTH(8), .DEPTH(DEPTH), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .reset(reset), .SW(SW), .KEY(KEY), .mem(mem),
    .core_hold(core_hold), .instr_count(instr_count), .byte_idx(byte_idx),
    .full(full), .LEDR(LEDR), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] addr; logic [15:0] data; } wr_t;
  wr_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: plain counters and a byte queue.
  int         m_addr, m_count;
  bit         m_full, m_run;
  logic [7:0] pend[$];
  logic [7:0] m_cks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = 0; m_count = 0; m_full = 0; m_run = 0; m_cks = 8'h00;
    pend.delete();
  endtask

  task automatic model_apply(input bit e, input bit r, input bit c, input logic [7:0] b);
    wr_t w;
    if (m_run) begin
      if (r) m_run = 0;
    end else if (c) begin
      m_addr = 0; m_count = 0; m_full = 0; m_cks = 8'h00;
      pend.delete();
    end else if (r) begin
      m_run = 1;
      pend.delete();
    end else if (e && !m_full) begin
      pend.push_back(b);
      if (pend.size() == 2) begin
        w.addr = 8'(m_addr);
        w.data = {pend[0], pend[1]};
        exp_q.push_back(w);
        m_cks  = m_cks ^ pend[0] ^ pend[1];
        m_addr = (m_addr + 1) % DEPTH;
        if (m_count < DEPTH) m_count++;
        if (m_count == DEPTH) m_full = 1;
        pend.delete();
      end
    end
  endtask

  task automatic press(input bit e, input bit r, input bit c, input logic [7:0] b);
    model_apply(e, r, c, b);
    @(negedge clk);
    SW  = {2'($urandom_range(0, 3)), b};
    KEY = {1'b1, ~c, ~r, ~e};
    repeat (DB + 8) @(negedge clk);
    KEY = 4'hF;
    repeat (DB + 8) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    logic [6:0] led_hi;
    logic [7:0] exp_cks;
`ifdef LOADER_CHECKSUM_EN
    exp_cks = m_cks;
    led_hi  = m_run ? 7'd0 : m_cks[6:0];
`else
    exp_cks = 8'h00;
    led_hi  = 7'd0;
`endif
    chk({tag, "_addr"},  32'(mem.load_addr), 32'(m_addr));
    chk({tag, "_count"}, 32'(instr_count), 32'(m_count));
    chk({tag, "_bidx"},  32'(byte_idx), 32'(pend.size()));
    chk({tag, "_full"},  32'(full), 32'(m_full));
    chk({tag, "_hold"},  32'(core_hold), 32'(!m_run));
    chk({tag, "_ledr"},  32'(LEDR), 32'({led_hi, pend.size() != 0, m_full, m_run}));
    chk({tag, "_cks"},   32'(checksum), 32'(exp_cks));
  endtask

  // Write monitor: every strobe is matched against the scoreboard queue.
  bit prev_we = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (mem.load_we) begin
        chk("we_hold", 32'(core_hold), 32'd1);
        chk("we_single", 32'(prev_we), 32'd0);
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write expected", mem.load_addr, mem.load_data);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_addr", 32'(mem.load_addr), 32'(w.addr));
          chk("wr_data", 32'(mem.load_data), 32'(w.data));
        end
      end
      prev_we = mem.load_we;
    end else begin
      prev_we = 0;
    end
  end

  initial begin
    bit found;
    int r;
    logic [7:0] b;
    model_reset();
    reset = 1'b1; KEY = 4'hF; SW = '0;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(mem.load_we), 32'd0);
    chk("rst_data", 32'(mem.load_data), 32'd0);
    check_state("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // First instruction, then checksum pattern.
    press(1, 0, 0, 8'h3A);
    press(1, 0, 0, 8'hC5);
    check_state("first");
    chk("first_data", 32'(mem.load_data), 32'h3AC5);
    press(1, 0, 0, 8'h0F);
    press(1, 0, 0, 8'h0F);
    check_state("cks");
`ifdef LOADER_CHECKSUM_EN
    chk("cks_ff", 32'(checksum), 32'hFF);
    chk("cks_led", 32'(LEDR[9:3]), 32'h7F);
`else
    chk("cks_off", 32'(checksum), 32'h0);
`endif

    // Bouncing enter key: nothing accepted until it settles.
    @(negedge clk);
    SW = 10'h0A5;
    for (int i = 0; i < 5; i++) begin
      KEY[0] = 1'b0; repeat (2) @(negedge clk);
      KEY[0] = 1'b1; repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("bounce_bidx", 32'(byte_idx), 32'd0);
    press(1, 0, 0, 8'hA5);
    check_state("bounce");

    // Fill to DEPTH, then extra enters are ignored.
    press(0, 0, 1, 8'h00);
    for (int i = 0; i < 2 * DEPTH + 2; i++) press(1, 0, 0, 8'($urandom));
    check_state("full");
    chk("full_led", 32'(LEDR[1]), 32'd1);
    press(0, 0, 1, 8'h00);
    check_state("clr");

    // Run discards the partial byte; halting appends at the retained address.
    press(1, 0, 0, 8'h11);
    press(1, 0, 0, 8'h22);
    press(1, 0, 0, 8'h33);
    press(0, 1, 0, 8'h00);
    check_state("run");
    press(1, 0, 0, 8'h44);
    press(0, 1, 0, 8'h00);
    check_state("halt");
    press(1, 0, 0, 8'h55);
    press(1, 0, 0, 8'h66);
    check_state("append");

    // Clear and enter together: clear wins.
    press(1, 0, 0, 8'h77);
    press(1, 0, 1, 8'h88);
    check_state("clr_ent");

    for (int i = 0; i < 50; i++) begin
      r = $urandom_range(0, 99);
      b = 8'($urandom);
      if (r < 65)      press(1, 0, 0, b);
      else if (r < 78) press(0, 1, 0, b);
      else if (r < 90) press(0, 0, 1, b);
      else             press(1, 0, 1, b);
      check_state("rand");
    end

    // Reset landing on the commit cycle.
    if (m_run) press(0, 1, 0, 8'h00);
    press(0, 0, 1, 8'h00);
    press(1, 0, 0, 8'hDE);
    @(negedge clk);
    SW = 10'h0AD; KEY[0] = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (mem.load_we) found = 1;
    end
    chk("rstc_seen", 32'(found), 32'd1);
    chk("rstc_data", 32'(mem.load_data), 32'hDEAD);
    reset = 1'b1;
    #1;
    chk("rstc_we", 32'(mem.load_we), 32'd0);
    chk("rstc_count", 32'(instr_count), 32'd0);
    KEY = 4'hF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (DB + 8) @(negedge clk);
    check_state("rstc");

    press(1, 0, 0, 8'hBE);
    press(1, 0, 0, 8'hEF);
    check_state("post");
    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
